b_reg_mp: RTL
=============

// Module: b_reg_mp
// PURPOSE
//  Parametrised multi-port register file for the decode stage of the MIPS pipeline.
//  - NUM_RD combinational read ports and NUM_WR synchronous write ports.
//  - Optional same-cycle write-to-read bypass; register 0 can be hard-wired to zero.
//  - Per-register pending scoreboard: set at issue, cleared at writeback. Hazard logic uses it to stall on load-use / multi-write.
// PARAMETERS
//  DATA_W    32                 data width in bits
//  DEPTH     32                 number of registers
//  ADDR_W    $clog2(DEPTH)      register address width (derived)
//  NUM_RD    2                  read port count (1..4)
//  NUM_WR    1                  write port count (1..2)
//  BYPASS    1                  1: a same-cycle write is forwarded to reads; 0: reads return stored value
//  ZERO_REG  1                  1: reg 0 reads 0, is never written and is never pending
// PORTS
//  i_sys_clock            in   1               clock; all state updates on rising edge
//  i_sys_reset            in   1               synchronous, active-high reset
//  i_b_regmp_rd_addr      in   NUM_RD*ADDR_W   read addresses; port p at [p*ADDR_W +: ADDR_W]
//  o_b_regmp_rd_data      out  NUM_RD*DATA_W   read data per port
//  o_b_regmp_rd_pend      out  NUM_RD          1 = addressed register awaits writeback
//  i_b_regmp_wr_en        in   NUM_WR          write enable per port
//  i_b_regmp_wr_addr      in   NUM_WR*ADDR_W   write addresses
//  i_b_regmp_wr_data      in   NUM_WR*DATA_W   write data
//  i_b_regmp_iss_en       in   1               mark i_b_regmp_iss_addr pending
//  i_b_regmp_iss_addr     in   ADDR_W          destination register of the issuing instruction
//  o_b_regmp_pend_cnt     out  ADDR_W+1        registered count of pending registers
// BEHAVIOUR
//  Reset
//  - On a rising edge with i_sys_reset=1: all registers <= 0, all pend bits <= 0, pend_cnt <= 0.
//  - Reset overrides any write or issue in the same cycle.
//  - Read outputs are combinational, so during and after reset rd_data=0 and rd_pend=0.
//  Writes
//  - At the rising edge, for each port w with wr_en[w]=1: reg[wr_addr[w]] <= wr_data[w].
//  - Two ports writing the same address: the higher-index port wins.
//  - With ZERO_REG=1, writes to address 0 are dropped.
//  - Addresses >= DEPTH (non-power-of-2 DEPTH) are ignored.
//  Reads (combinational, 0-cycle latency)
//  - With BYPASS=1, if any enabled write port targets rd_addr[p] (nonzero when ZERO_REG=1):
//      rd_data[p] = that write's data (highest-index port wins) and rd_pend[p] = 0.
//  - Otherwise rd_data[p] = reg[rd_addr[p]] and rd_pend[p] = pend[rd_addr[p]].
//  - ZERO_REG=1 and rd_addr[p]=0: rd_data[p]=0 and rd_pend[p]=0, always.
//  - With BYPASS=0, the written value is visible from the cycle after the edge.
//  Scoreboard (one pend bit per register, updated at the rising edge)
//  - An enabled write to address A clears pend[A].
//  - iss_en=1 sets pend[iss_addr]. Issue has priority over a clear to the same address in the same cycle (the new producer owns it).
//  - Issuing to an already-pending register keeps it pending; there is no count of outstanding producers.
//  - ZERO_REG=1: issue to address 0 is ignored.
//  - pend_cnt = popcount of the pend bits; registered, so it reflects state after the edge. Range 0..DEPTH, no wrap.
//  General
//  - No internal FSM beyond the storage arrays.
//  - All outputs are fully defined for any input combination; no X propagation from unwritten state after reset.
// TESTING
//  1 Reset: assert reset 1 cycle with wr_en=1, addr=8, data=0x1234
//      -> reg8 reads 0, pend_cnt=0.
//  2 Write/read: write 0x1234 to r8; next cycle read r8 on port0, r9 on port1
//      -> 0x1234 and 0x0. With BYPASS=1, same-cycle read of r8 during the write -> 0x1234.
//  3 Zero reg: write 0x9876 to r0 with iss_en=1, iss_addr=0
//      -> r0 reads 0, rd_pend=0, pend_cnt unchanged.
//  4 Scoreboard: issue r5 -> pend_cnt=1 and rd_pend=1 for r5.
//      Write r5=0xABCD -> pend cleared, count=0.
//      Same-cycle issue r5 and write r5 -> r5 stays pending, data=new.
//  5 Dual write (NUM_WR=2): port0 writes r3=0x1111 and port1 writes r3=0x2222 in the same cycle
//      -> r3=0x2222. Bypassed read in that cycle also returns 0x2222.
//  6 Mid-operation reset: issue r1..r4, then assert reset
//      -> pend_cnt=0 and all reads 0 on the following cycle.

Source files
------------

// File: rtl/b_reg_mp.sv
// Multi-port register file with write-to-read bypass, hard-wired zero register
// and a per-register pending scoreboard; reads are combinational, writes land on the rising edge.
module b_reg_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     i_sys_clock,
    input  logic                     i_sys_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_b_regmp_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_b_regmp_rd_data,
    output logic [NUM_RD-1:0]        o_b_regmp_rd_pend,
    input  logic [NUM_WR-1:0]        i_b_regmp_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_b_regmp_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_b_regmp_wr_data,
    input  logic                     i_b_regmp_iss_en,
    input  logic [ADDR_W-1:0]        i_b_regmp_iss_addr,
    output logic [ADDR_W:0]          o_b_regmp_pend_cnt
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [NUM_WR-1:0] wr_ok;
    logic              iss_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // A write or issue counts only when it targets a real, writable register.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = i_b_regmp_wr_en[w]
                     && in_range(i_b_regmp_wr_addr[w*ADDR_W +: ADDR_W])
                     && !is_zero(i_b_regmp_wr_addr[w*ADDR_W +: ADDR_W]);
        end
        iss_ok = i_b_regmp_iss_en && in_range(i_b_regmp_iss_addr)
               && !is_zero(i_b_regmp_iss_addr);
    end

    // Writeback clears first, then issue sets: the new producer owns the register.
    always_comb begin
        pend_nxt = pend;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                pend_nxt[i_b_regmp_wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_ok) begin
            pend_nxt[i_b_regmp_iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend               <= '0;
            o_b_regmp_pend_cnt <= '0;
        end else begin
            // Later loop iterations override earlier ones, so the higher port wins.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    regs[i_b_regmp_wr_addr[w*ADDR_W +: ADDR_W]] <= i_b_regmp_wr_data[w*DATA_W +: DATA_W];
                end
            end
            pend               <= pend_nxt;
            o_b_regmp_pend_cnt <= popcount(pend_nxt);
        end
    end

    always_comb begin
        o_b_regmp_rd_data = '0;
        o_b_regmp_rd_pend = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] ra;
            ra = i_b_regmp_rd_addr[p*ADDR_W +: ADDR_W];
            if (in_range(ra)) begin
                o_b_regmp_rd_data[p*DATA_W +: DATA_W] = regs[ra];
                o_b_regmp_rd_pend[p]                  = pend[ra];
            end
            if (BYPASS) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (i_b_regmp_wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
                        o_b_regmp_rd_data[p*DATA_W +: DATA_W] = i_b_regmp_wr_data[w*DATA_W +: DATA_W];
                        o_b_regmp_rd_pend[p]                  = 1'b0;
                    end
                end
            end
            // Reset gating keeps reads at zero while reset is held, before the first edge clears state.
            if (is_zero(ra) || i_sys_reset) begin
                o_b_regmp_rd_data[p*DATA_W +: DATA_W] = '0;
                o_b_regmp_rd_pend[p]                  = 1'b0;
            end
        end
    end

endmodule
